aha_reset_req_initiator: RTL and testbench

- Requester-side partner of the platform reset generators. Drives one four-phase REQ/ACK reset-request handshake toward a reset generator channel (DMA, NIC, TLX, CGRA, TIMER, UART, WDOG and similar).
- Software or a register block pulses START. The block raises REQ, waits for ACK, drops REQ, waits for ACK to fall, then reports DONE.
- A bounded timeout on each phase prevents a hung reset domain from wedging the requester.
- One instance per reset channel, placed in the platform controller register path.

---
 rtl/aha_reset_req_initiator_if.sv | 23 ++
 rtl/aha_reset_req_initiator.sv | 162 ++++++++++++++++
 tb/tb_aha_reset_req_initiator.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/aha_reset_req_initiator_if.sv
// Reset-request handshake bundle between a requester and one reset-generator channel.
// The master modport is the requester FSM; the slave modport is the register path/generator side.
interface aha_reset_req_initiator_if;
   logic       START;
   logic       ABORT;
   logic       REQ;
   logic       ACK;
   logic       BUSY;
   logic       DONE;
   logic       TIMEOUT_ERR;
   logic       ABORTED;
   logic [1:0] STATE;

   modport master (
      input  START, ABORT, ACK,
      output REQ, BUSY, DONE, TIMEOUT_ERR, ABORTED, STATE
   );

   modport slave (
      output START, ABORT, ACK,
      input  REQ, BUSY, DONE, TIMEOUT_ERR, ABORTED, STATE
   );
endinterface

// File: rtl/aha_reset_req_initiator.sv
// Four-phase REQ/ACK reset-request initiator with per-phase timeout and abort.
// Define AHA_RESET_REQ_ACK_SYNC_EN to pass ACK through a 2-flop synchronizer (generator on another clock).
module aha_reset_req_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9
) (
   input logic                        CLK,
   input logic                        RESETn,
   aha_reset_req_initiator_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2,
      CMPL   = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic ack_s;

`ifdef AHA_RESET_REQ_ACK_SYNC_EN
   logic ack_meta_q, ack_sync_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         ack_meta_q <= 1'b0;
         ack_sync_q <= 1'b0;
      end else begin
         ack_meta_q <= bus.ACK;
         ack_sync_q <= ack_meta_q;
      end
   end

   assign ack_s = ack_sync_q;
`else
   assign ack_s = bus.ACK;
`endif

   state_e           state_q, state_d;
   logic             req_q, req_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             terr_q, terr_d;
   logic             abrt_q, abrt_d;
   logic             tflag_q, tflag_d;
   logic             aflag_q, aflag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_last;

   assign cnt_last = (cnt_q == CNT_LAST);
   assign cnt_inc  = cnt_last ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
         abrt_q  <= 1'b0;
         tflag_q <= 1'b0;
         aflag_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
         abrt_q  <= abrt_d;
         tflag_q <= tflag_d;
         aflag_q <= aflag_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      done_d  = 1'b0;
      terr_d  = terr_q;
      abrt_d  = abrt_q;
      tflag_d = tflag_q;
      aflag_d = aflag_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            // A stale ACK blocks the request so REQ never rises against ACK=1.
            if (bus.START && !ack_s) begin
               state_d = REQ_HI;
               req_d   = 1'b1;
               terr_d  = 1'b0;
               abrt_d  = 1'b0;
               cnt_d   = '0;
            end
         end

         REQ_HI: begin
            cnt_d = cnt_inc;
            if (ack_s) begin
               state_d = REQ_LO;
               req_d   = 1'b0;
               cnt_d   = '0;
            end else if (bus.ABORT) begin
               state_d = REQ_LO;
               req_d   = 1'b0;
               aflag_d = 1'b1;
               cnt_d   = '0;
            end else if (cnt_last) begin
               state_d = REQ_LO;
               req_d   = 1'b0;
               tflag_d = 1'b1;
               cnt_d   = '0;
            end
         end

         REQ_LO: begin
            cnt_d = cnt_inc;
            if (!ack_s) begin
               // Outcome is published on CMPL entry so it is visible during CMPL.
               state_d = CMPL;
               cnt_d   = '0;
               if (tflag_q)      terr_d = 1'b1;
               else if (aflag_q) abrt_d = 1'b1;
               else              done_d = 1'b1;
            end else if (cnt_last) begin
               state_d = IDLE;
               terr_d  = 1'b1;
               tflag_d = 1'b0;
               aflag_d = 1'b0;
               cnt_d   = '0;
            end
         end

         CMPL: begin
            state_d = IDLE;
            tflag_d = 1'b0;
            aflag_d = 1'b0;
            cnt_d   = '0;
         end

         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.REQ         = req_q;
   assign bus.BUSY        = busy_q;
   assign bus.DONE        = done_q;
   assign bus.TIMEOUT_ERR = terr_q;
   assign bus.ABORTED     = abrt_q;
   assign bus.STATE       = state_q;

endmodule

// File: tb/tb_aha_reset_req_initiator.sv
// Bench for aha_reset_req_initiator: directed and random handshakes checked against
// a closed-form transaction model of REQ duration, outcome and completion timing.
module tb_aha_reset_req_initiator;
   localparam int T     = 16;
   localparam int NEVER = 1000;
`ifdef AHA_RESET_REQ_ACK_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic CLK    = 1'b0;
   logic RESETn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   aha_reset_req_initiator_if bus();

   aha_reset_req_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int f;      // cycle of first REQ=0, counted from first REQ=1 cycle
      int done;   // DONE cycle or -1
      int idle;   // first BUSY=0 cycle
      int terr;
      int abrt;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ACK is high for cycles [ra, f+fd) if REQ was still high at cycle ra; ab is the ABORT cycle.
   function automatic exp_t model(input int ra, input int ab, input int fd);
      exp_t e;
      int   hi_end, why, m;
      bit   rose;
      hi_end = T - 1;
      why    = 2;
      if (ab >= 0 && ab < ra + L && ab < hi_end) begin
         hi_end = ab;
         why    = 1;
      end
      if (ra + L <= hi_end) begin
         hi_end = ra + L;
         why    = 0;
      end
      e.f  = hi_end + 1;
      rose = (ra < e.f);
      m    = (!rose || e.f < ra + L) ? 0 : fd + L;
      if (m <= T - 1) begin
         e.done = (why == 0) ? e.f + m + 1 : -1;
         e.idle = e.f + m + 2;
         e.terr = (why == 2) ? 1 : 0;
         e.abrt = (why == 1) ? 1 : 0;
      end else begin
         e.done = -1;
         e.idle = e.f + T;
         e.terr = 1;
         e.abrt = 0;
      end
      return e;
   endfunction

   task automatic run_txn(input int ra, input int ab, input int fd, input int sb);
      exp_t e;
      int   n, f_m, done_m, ndone, idle_m;
      bit   risen;
      e = model(ra, ab, fd);
      f_m = -1; done_m = -1; ndone = 0; idle_m = -1; risen = 0; n = 0;
      @(negedge CLK);
      bus.START = 1'b1; bus.ACK = 1'b0; bus.ABORT = 1'b0;
      while (n < 3*T + 10 && idle_m < 0) begin
         @(negedge CLK);
         bus.START = 1'b0;
         if (n == 0) begin
            chk("req_rise", 32'(bus.REQ), 1);
            chk("state_req_hi", 32'(bus.STATE), 1);
            chk("flags_cleared", 32'({bus.TIMEOUT_ERR, bus.ABORTED}), 0);
         end
         if (!bus.REQ && f_m < 0) f_m = n;
         if (bus.DONE) begin
            ndone++;
            if (done_m < 0) done_m = n;
         end
         if (!bus.BUSY) idle_m = n;
         if (n == ra && bus.REQ) risen = 1;
         bus.ACK   = risen && !(f_m >= 0 && n >= f_m + fd);
         bus.ABORT = (n == ab);
         bus.START = (n == sb) && bus.BUSY;
         n++;
      end
      chk("idle_reached", 32'(idle_m >= 0), 1);
      chk("req_hi_len", 32'(f_m), 32'(e.f));
      chk("done_count", 32'(ndone), 32'(e.done >= 0));
      if (e.done >= 0) chk("done_cycle", 32'(done_m), 32'(e.done));
      chk("idle_cycle", 32'(idle_m), 32'(e.idle));
      chk("timeout_err", 32'(bus.TIMEOUT_ERR), 32'(e.terr));
      chk("aborted", 32'(bus.ABORTED), 32'(e.abrt));
      chk("state_idle", 32'(bus.STATE), 0);
      chk("req_idle", 32'(bus.REQ), 0);
      if (bus.ACK) begin
         // Stale ACK: START must be dropped and sticky flags untouched.
         bus.START = 1'b1;
         @(negedge CLK);
         bus.START = 1'b0;
         repeat (3) begin
            @(negedge CLK);
            chk("stale_busy", 32'(bus.BUSY), 0);
            chk("stale_req", 32'(bus.REQ), 0);
         end
         chk("stale_terr", 32'(bus.TIMEOUT_ERR), 32'(e.terr));
      end
      bus.ACK = 1'b0; bus.ABORT = 1'b0; bus.START = 1'b0;
      repeat (L + 2) @(negedge CLK);
   endtask

   initial begin
      int ra, ab, fd, sb;
      bus.START = 1'b0; bus.ABORT = 1'b0; bus.ACK = 1'b0;
      RESETn = 1'b0;
      #12;
      chk("rst_req", 32'(bus.REQ), 0);
      chk("rst_busy", 32'(bus.BUSY), 0);
      chk("rst_done", 32'(bus.DONE), 0);
      chk("rst_terr", 32'(bus.TIMEOUT_ERR), 0);
      chk("rst_aborted", 32'(bus.ABORTED), 0);
      chk("rst_state", 32'(bus.STATE), 0);
      @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);

      run_txn(3, -1, 2, -1);          // normal handshake
      run_txn(NEVER, -1, 0, 5);       // REQ_HI timeout, START while busy
      run_txn(1, -1, NEVER, -1);      // REQ_LO timeout with stale ACK
      run_txn(NEVER, 2, 0, -1);       // abort
      run_txn(0, -1, 0, -1);          // next START clears ABORTED
      run_txn(T - 1, -1, 0, -1);      // ACK on last cycle beats timeout
      run_txn(4, 4, 1, -1);           // ACK and ABORT together
      run_txn(2, -1, T - 1, -1);      // ACK falls on last REQ_LO cycle

      for (int i = 0; i < 24; i++) begin
         ra = int'($urandom_range(0, T + 2));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T - 3)) : -1;
         fd = int'($urandom_range(0, T + 3));
         sb = int'($urandom_range(1, T));
         run_txn(ra, ab, fd, sb);
      end

      // Asynchronous reset in the middle of REQ_HI.
      @(negedge CLK);
      bus.START = 1'b1;
      @(negedge CLK);
      bus.START = 1'b0;
      @(negedge CLK);
      chk("pre_rst_req", 32'(bus.REQ), 1);
      #2 RESETn = 1'b0;
      #1;
      chk("async_rst_req", 32'(bus.REQ), 0);
      chk("async_rst_busy", 32'(bus.BUSY), 0);
      chk("async_rst_state", 32'(bus.STATE), 0);
      chk("async_rst_flags", 32'({bus.TIMEOUT_ERR, bus.ABORTED, bus.DONE}), 0);
      @(negedge CLK);
      RESETn = 1'b1;
      repeat (2) @(negedge CLK);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
